counter_mod_n: RTL and testbench

Parametrised synchronous modulo-N counter built on the team's D flip-flop counting style, generalising the fixed 2-bit enabled counter to arbitrary width and modulus. It adds up/down direction, parallel load, a combinational terminal-count output, a registered wrap pulse and an optional one-hot state decode. It sits in the control path as a sequencer or timer: TC chains to the next stage's E, and the decode drives per-state strobes.

---
 rtl/counter_mod_n_if.sv | 25 ++
 rtl/counter_mod_n.sv | 87 ++++++++
 tb/tb_counter_mod_n.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/counter_mod_n_if.sv
// Control and status bundle for counter_mod_n: the driver side issues enable/direction/load,
// the counter side returns the count, terminal count, wrap pulse and one-hot decode.
interface counter_mod_n_if #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10
);
  logic               E;
  logic               UP;
  logic               LD;
  logic [WIDTH-1:0]   D;
  logic [WIDTH-1:0]   Q;
  logic               TC;
  logic               WRAP;
  logic [MODULUS-1:0] S;

  modport master (
    output E, UP, LD, D,
    input  Q, TC, WRAP, S
  );

  modport slave (
    input  E, UP, LD, D,
    output Q, TC, WRAP, S
  );
endinterface

// File: rtl/counter_mod_n.sv
// Modulo-N up/down counter with clamped parallel load, combinational TC and registered WRAP pulse.
// Define COUNTER_DECODE_EN to build the registered one-hot state decode on S; otherwise S is tied low.
module counter_mod_n #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10
) (
  input  logic           CLK,
  input  logic           CLRN,
  counter_mod_n_if.slave bus
);
  localparam logic [WIDTH:0]   LP_MOD    = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH-1:0] LP_LAST_Q = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] r_q;
  logic             r_wrap;

  logic [WIDTH:0]   w_up_ext;
  logic [WIDTH-1:0] w_up_val;
  logic [WIDTH-1:0] w_dn_val;
  logic [WIDTH-1:0] w_ld_val;
  logic             w_at_top;
  logic             w_at_zero;
  logic             w_tc;
  logic [WIDTH-1:0] w_q_nxt;
  logic             w_wrap_nxt;

  // Increment is formed one bit wider so MODULUS = 2^WIDTH still compares cleanly.
  assign w_up_ext  = {1'b0, r_q} + 1'b1;
  assign w_up_val  = (w_up_ext == LP_MOD) ? '0 : w_up_ext[WIDTH-1:0];
  assign w_at_zero = (r_q == '0);
  assign w_at_top  = (r_q == LP_LAST_Q);
  assign w_dn_val  = w_at_zero ? LP_LAST_Q : (r_q - 1'b1);
  assign w_ld_val  = ({1'b0, bus.D} < LP_MOD) ? bus.D : LP_LAST_Q;

  assign w_tc      = bus.E & (bus.UP ? w_at_top : w_at_zero);

  always_comb begin
    w_q_nxt    = r_q;
    w_wrap_nxt = 1'b0;
    if (bus.LD) begin
      w_q_nxt = w_ld_val;
    end else if (bus.E) begin
      w_q_nxt    = bus.UP ? w_up_val : w_dn_val;
      w_wrap_nxt = w_tc;
    end
  end

`ifdef COUNTER_DECODE_EN
  localparam logic [MODULUS-1:0] LP_ONE = {{(MODULUS-1){1'b0}}, 1'b1};

  logic [MODULUS-1:0] r_s;
  logic [MODULUS-1:0] w_s_nxt;

  // Decode is taken from the next count so S lines up with Q in the same cycle.
  assign w_s_nxt = LP_ONE << w_q_nxt;

  always_ff @(posedge CLK) begin
    if (!CLRN) begin
      r_q    <= '0;
      r_wrap <= 1'b0;
      r_s    <= LP_ONE;
    end else begin
      r_q    <= w_q_nxt;
      r_wrap <= w_wrap_nxt;
      r_s    <= w_s_nxt;
    end
  end

  assign bus.S = r_s;
`else
  always_ff @(posedge CLK) begin
    if (!CLRN) begin
      r_q    <= '0;
      r_wrap <= 1'b0;
    end else begin
      r_q    <= w_q_nxt;
      r_wrap <= w_wrap_nxt;
    end
  end

  assign bus.S = '0;
`endif

  assign bus.Q    = r_q;
  assign bus.TC   = w_tc;
  assign bus.WRAP = r_wrap;
endmodule

// File: tb/tb_counter_mod_n.sv
// Bench for counter_mod_n (WIDTH=4, MODULUS=10): directed vectors with literal expectations,
// plus a modulo-arithmetic reference checked against the DUT on every falling edge.
module tb_counter_mod_n;
  localparam int W = 4;
  localparam int M = 10;
`ifdef COUNTER_DECODE_EN
  localparam int DEC = 1;
`else
  localparam int DEC = 0;
`endif

  logic CLK  = 1'b0;
  logic CLRN = 1'b0;

  counter_mod_n_if #(.WIDTH(W), .MODULUS(M)) bus ();

  counter_mod_n #(.WIDTH(W), .MODULUS(M)) dut (
    .CLK  (CLK),
    .CLRN (CLRN),
    .bus  (bus)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: plain modulo arithmetic on an integer count.
  int m_q     = 0;
  int m_wrap  = 0;
  int m_valid = 0;

  always @(posedge CLK) begin
    if (!CLRN) begin
      m_q     <= 0;
      m_wrap  <= 0;
      m_valid <= 1;
    end else if (bus.LD) begin
      m_q    <= (int'(bus.D) < M) ? int'(bus.D) : M - 1;
      m_wrap <= 0;
    end else if (bus.E) begin
      if (bus.UP) begin
        m_q    <= (m_q + 1) % M;
        m_wrap <= (m_q == M - 1) ? 1 : 0;
      end else begin
        m_q    <= (m_q + M - 1) % M;
        m_wrap <= (m_q == 0) ? 1 : 0;
      end
    end else begin
      m_wrap <= 0;
    end
  end

  function automatic int exp_s(input int q);
    return DEC ? (1 << q) : 0;
  endfunction

  function automatic int exp_tc(input int q, input logic e, input logic up);
    if (!e) return 0;
    return up ? ((q == M - 1) ? 1 : 0) : ((q == 0) ? 1 : 0);
  endfunction

  always @(negedge CLK) begin
    if (m_valid != 0) begin
      chk("model_q",    int'(bus.Q),    m_q);
      chk("model_wrap", int'(bus.WRAP), m_wrap);
      chk("model_tc",   int'(bus.TC),   exp_tc(m_q, bus.E, bus.UP));
      chk("model_s",    int'(bus.S),    exp_s(m_q));
    end
  end

  // Apply inputs, take one rising edge, settle just after it.
  task automatic drive(input logic clrn, input logic e, input logic up,
                       input logic ld, input logic [W-1:0] d);
    CLRN   = clrn;
    bus.E  = e;
    bus.UP = up;
    bus.LD = ld;
    bus.D  = d;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    bus.E  = 1'b1;
    bus.UP = 1'b0;
    bus.LD = 1'b0;
    bus.D  = '0;

    // Reset with E=1, counting down: sitting at terminal.
    drive(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
    chk("rst_q",    int'(bus.Q),    0);
    chk("rst_s",    int'(bus.S),    DEC ? 1 : 0);
    chk("rst_wrap", int'(bus.WRAP), 0);
    chk("rst_tc_dn", int'(bus.TC),  1);
    bus.UP = 1'b1;
    #1;
    chk("rst_tc_up", int'(bus.TC),  0);

    // Up-count through a full cycle.
    for (int i = 1; i <= 10; i++) begin
      drive(1'b1, 1'b1, 1'b1, 1'b0, 4'd0);
      chk("up_q",    int'(bus.Q),    (i == 10) ? 0 : i);
      chk("up_wrap", int'(bus.WRAP), (i == 10) ? 1 : 0);
      chk("up_tc",   int'(bus.TC),   (i == 9) ? 1 : 0);
    end
    chk("up_s0", int'(bus.S), DEC ? 1 : 0);

    // Down wrap, then a direction flip re-evaluates TC without an edge.
    drive(1'b1, 1'b1, 1'b1, 1'b0, 4'd0);
    chk("dn_pre_q", int'(bus.Q), 1);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
    chk("dn_q0",    int'(bus.Q),    0);
    chk("dn_wrap0", int'(bus.WRAP), 0);
    chk("dn_tc0",   int'(bus.TC),   1);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
    chk("dn_q9",    int'(bus.Q),    9);
    chk("dn_wrap9", int'(bus.WRAP), 1);
    chk("dn_s9",    int'(bus.S),    DEC ? 512 : 0);
    chk("dn_tc9",   int'(bus.TC),   0);
    bus.UP = 1'b1;
    #1;
    chk("flip_tc",  int'(bus.TC),   1);

    // Loads: in range, clamped, and load beating a pending wrap.
    drive(1'b1, 1'b0, 1'b1, 1'b1, 4'd6);
    chk("ld6_q",    int'(bus.Q),    6);
    chk("ld6_s",    int'(bus.S),    DEC ? 64 : 0);
    drive(1'b1, 1'b0, 1'b1, 1'b1, 4'd13);
    chk("ld13_q",   int'(bus.Q),    9);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 4'd3);
    chk("ldE_q",    int'(bus.Q),    3);
    chk("ldE_wrap", int'(bus.WRAP), 0);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 4'd15);
    chk("ld15_q",   int'(bus.Q),    9);

    // Hold, then reset mid-count.
    drive(1'b1, 1'b0, 1'b1, 1'b1, 4'd7);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 1'b1, 1'b0, 4'd0);
      chk("hold_q",    int'(bus.Q),    7);
      chk("hold_wrap", int'(bus.WRAP), 0);
      chk("hold_tc",   int'(bus.TC),   0);
    end
    drive(1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
    chk("midrst_q",    int'(bus.Q),    0);
    chk("midrst_wrap", int'(bus.WRAP), 0);

    // Reset wins over a wrap that would otherwise occur on this edge.
    drive(1'b1, 1'b0, 1'b1, 1'b1, 4'd9);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
    chk("rstwrap_q",    int'(bus.Q),    0);
    chk("rstwrap_wrap", int'(bus.WRAP), 0);

    // Mixed directed tail exercised only by the reference compare.
    drive(1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 4'd0);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 4'd0);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 4'd0);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
